// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU with single-cycle logic/arith ops plus
//               iterative shift-add multiply and restoring unsigned divide.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 19,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             dz
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;
  localparam int         MSB     = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d, rem_q, rem_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

  // Single-cycle datapath, evaluated directly on the incoming operands
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] sll_wide;
  logic [WIDTH-1:0]   op_res, op_rem;
  logic               op_carry, op_ovf, op_dz, op_iter;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];
  assign sll_wide = {{WIDTH{1'b0}}, a} << shamt;

  always_comb begin
    op_res   = '0;
    op_rem   = '0;
    op_carry = 1'b0;
    op_ovf   = 1'b0;
    op_dz    = 1'b0;
    op_iter  = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        op_res   = add_sum[WIDTH-1:0];
        op_carry = add_sum[WIDTH];
        op_ovf   = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        op_res   = sub_diff[WIDTH-1:0];
        op_carry = sub_diff[WIDTH];
        op_ovf   = (a[MSB] != b[MSB]) && (sub_diff[MSB] != a[MSB]);
      end
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_XOR: op_res = a ^ b;
      OP_SLL: begin
        if (int'(shamt) >= WIDTH) begin
          op_res   = '0;
          op_carry = |a;
        end else begin
          op_res   = sll_wide[WIDTH-1:0];
          op_carry = |sll_wide[2*WIDTH-1:WIDTH];
        end
      end
      OP_MUL: op_iter = 1'b1;
      default: begin
        if (b == '0) begin
          op_res = '1;
          op_rem = a;
          op_dz  = 1'b1;
        end else begin
          op_iter = 1'b1;
        end
      end
    endcase
  end

  // One iteration step: MUL keeps {hi,lo} = partial product / remaining
  // multiplier; DIVU keeps hi = partial remainder, lo = dividend/quotient.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ok, is_mul;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo, step_hi, step_lo;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign mul_hi   = mul_sum[WIDTH:1];
  assign mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign div_sh   = {hi_q, lo_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ok   = ~div_diff[WIDTH];
  assign div_hi   = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_lo   = {lo_q[WIDTH-2:0], div_ok};
  assign is_mul   = (op_q == OP_MUL);
  assign step_hi  = is_mul ? mul_hi : div_hi;
  assign step_lo  = is_mul ? mul_lo : div_lo;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    rem_d    = rem_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d  = a;
          b_d  = b;
          op_d = alu_ctrl;
          if (op_iter) begin
            state_d = ITER;
            cnt_d   = SHW'(WIDTH - 1);
            hi_d    = '0;
            lo_d    = (alu_ctrl == OP_MUL) ? b : a;
          end else begin
            state_d  = DONE;
            result_d = op_res;
            rem_d    = op_rem;
            zero_d   = (op_res == '0);
            carry_d  = op_carry;
            ovf_d    = op_ovf;
            dz_d     = op_dz;
          end
        end
      end
      ITER: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = step_lo;
          rem_d    = is_mul ? '0 : step_hi;
          zero_d   = (step_lo == '0);
          carry_d  = is_mul & (|step_hi);
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      rem_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign rem       = rem_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

`default_nettype wire
